counter_mod_updown: RTL

- Parametrised modulo-N up/down counter; generalises the fixed 0..9999 tick counter used by the stopwatch/watch datapath behind the UART FIFO.
- Adds synchronous clear and parallel load, wrap or saturate selection, and registered carry/borrow pulses so instances cascade (e.g. ms -> sec -> min).
- One instance per digit group; driven by a shared tick generator in the clk domain.

---
 rtl/counter_mod_updown.sv | 130 +++++++++++++
 1 files changed

// File: rtl/counter_mod_updown.sv
// ---------------------------------------------------------------------------
// counter_mod_updown
//   Parametrised modulo-(MAX_COUNT+1) up/down counter for the stopwatch/watch
//   datapath. Supports synchronous clear, clamped parallel load, wrap or
//   saturate at the bounds, and registered carry/borrow pulses so several
//   instances cascade (upstream o_carry/o_borrow -> downstream i_tick).
//
//   Optional feature macro: COUNTER_CMP_EN
//     defined   : o_cmp_hit pulses for one cycle when a tick or load moves the
//                 count onto min(i_cmp_val, MAX_COUNT).
//     undefined : o_cmp_hit is tied low and i_cmp_val is ignored.
//
//   Parameter constraints: MAX_COUNT >= 1 and 2**WIDTH > MAX_COUNT.
// ---------------------------------------------------------------------------
module counter_mod_updown #(
  parameter int MAX_COUNT = 9999,
  parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,         // asynchronous, active-low
  input  logic             i_tick,
  input  logic             i_mode,      // 0 = up, 1 = down
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_wrap,      // 1 = wrap, 0 = saturate
  input  logic [WIDTH-1:0] i_cmp_val,
  output logic [WIDTH-1:0] o_count,
  output logic             o_carry,
  output logic             o_borrow,
  output logic             o_at_max,
  output logic             o_at_min,
  output logic             o_cmp_hit
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] load_clamped;
  logic             carry_q;
  logic             carry_nxt;
  logic             borrow_q;
  logic             borrow_nxt;

  // Out-of-range loads saturate to the terminal value so the count never
  // leaves 0..MAX_COUNT.
  assign load_clamped = (i_load_val > MAX_VAL) ? MAX_VAL : i_load_val;

  // Next-state: clear beats load beats tick; carry/borrow only on a wrap.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    count_nxt  = count_q;
    carry_nxt  = 1'b0;
    borrow_nxt = 1'b0;
    if (i_clear) begin
      count_nxt = '0;
    end else if (i_load) begin
      count_nxt = load_clamped;
    end else if (i_tick) begin
      if (!i_mode) begin
        if (count_q != MAX_VAL) begin
          count_nxt = count_q + 1'b1;
        end else if (i_wrap) begin
          count_nxt = '0;
          carry_nxt = 1'b1;
        end
      end else begin
        if (count_q != '0) begin
          count_nxt = count_q - 1'b1;
        end else if (i_wrap) begin
          count_nxt  = MAX_VAL;
          borrow_nxt = 1'b1;
        end
      end
    end
  end

  // Count and wrap pulses register together so a pulse lines up with the
  // wrapped count value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its peers.
      count_q  <= count_nxt;
      carry_q  <= carry_nxt;
      borrow_q <= borrow_nxt;
    end
  end

  assign o_count  = count_q;
  assign o_carry  = carry_q;
  assign o_borrow = borrow_q;
  assign o_at_max = (count_q == MAX_VAL);
  assign o_at_min = (count_q == '0);

`ifdef COUNTER_CMP_EN
  logic [WIDTH-1:0] cmp_target;
  logic             moved;
  logic             cmp_nxt;
  logic             cmp_q;

  assign cmp_target = (i_cmp_val > MAX_VAL) ? MAX_VAL : i_cmp_val;
  // A hit needs the count to actually move by tick or load; clear, saturated
  // holds and a count already sitting on the target never fire.
  assign moved      = !i_clear && (i_load || i_tick) && (count_nxt != count_q);
  assign cmp_nxt    = moved && (count_nxt == cmp_target);

  // Compare pulse registered alongside the count it refers to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_q <= 1'b0;
    end else begin
      cmp_q <= cmp_nxt;
    end
  end

  assign o_cmp_hit = cmp_q;
`else
  logic unused_cmp_val;
  assign unused_cmp_val = ^i_cmp_val;
  assign o_cmp_hit      = 1'b0;
`endif

endmodule
